acq_card_reg_read_resp: RTL and testbench
=========================================

ACQ_CARD_REG_READ_RESP -- requirements
Module: acq_card_reg_read_resp

Interface
REQ-001 SHALL have parameter DW, default ACQ_CARD_DATA_DW (32), meaning read data width.
REQ-002 SHALL have parameter AW, default MEM_AW (9), meaning host word-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rd_req_valid  input  1  host read request valid.
REQ-006 SHALL have port rd_req_ready  output  1  request accepted when high with rd_req_valid.
REQ-007 SHALL have port rd_req_addr  input  AW  word address.
REQ-008 SHALL have port rd_resp_valid  output  1  response valid.
REQ-009 SHALL have port rd_resp_ready  input  1  host consumes response.
REQ-010 SHALL have port rd_resp_data  output  DW  read data.
REQ-011 SHALL have port rd_resp_err  output  1  address decode error.
REQ-012 SHALL have port st_reg  input  ST_REG_NUM x DW  live status words.
REQ-013 SHALL have port ctrl_reg  input  ACQ_CARD_REG_NUM x DW  current control-register values from the write side.
REQ-014 SHALL have port snap_cnt  output  16  count of status snapshots taken.

Function
REQ-015 SHALL implement the read-side responder complementing the control-register writer: addresses 0..ST_REG_NUM-1 map to status, ST_REG_NUM..ST_REG_NUM+ACQ_CARD_REG_NUM-1 map to ctrl_reg[addr-ST_REG_NUM].
REQ-016 SHALL use FSM states IDLE and RESP; IDLE->RESP on request handshake; RESP->IDLE on response handshake with no new request; RESP->RESP on response handshake coinciding with a new request handshake.
REQ-017 SHALL drive rd_req_ready = (state==IDLE) | rd_resp_ready, giving at most one outstanding response and back-to-back throughput of one read per cycle.
REQ-018 SHALL assert rd_resp_valid exactly one cycle after request handshake (latency 1), and hold rd_resp_valid/data/err stable while rd_resp_ready is low.
REQ-019 SHALL, on accepted read of address 0, latch all ST_REG_NUM status words into a snapshot array in the handshake cycle and return the live st_reg[0] value.
REQ-020 SHALL return snapshot words (not live inputs) for status addresses 1..ST_REG_NUM-1, guaranteeing multi-word coherence.
REQ-021 SHALL increment snap_cnt by 1 per snapshot, wrapping 0xFFFF->0x0000.
REQ-022 SHALL return ctrl_reg values sampled at the handshake cycle (live, no snapshot).
REQ-023 SHALL return data 0 with rd_resp_err=1 for ctrl index >= ACQ_CARD_REG_REAL_NUM or address >= ST_REG_NUM+ACQ_CARD_REG_NUM; rd_resp_err=0 otherwise.
REQ-024 SHALL ignore rd_req_addr while no handshake occurs; requests while rd_req_ready low are neither accepted nor dropped (host holds them).

Reset
REQ-025 SHALL, while rst_n low at a clock edge: state=IDLE, rd_resp_valid=0, rd_resp_data=0, rd_resp_err=0, snap_cnt=0, snapshot array all 0.
REQ-026 SHALL discard a pending response on reset mid-transaction; no response is issued after rst_n deasserts.
REQ-027 SHALL hold rd_req_ready=0 in the cycle rst_n is low.

Structure
REQ-028 SHALL take ST_REG_NUM, ACQ_CARD_REG_NUM, ACQ_CARD_REG_REAL_NUM, MEM_AW, ACQ_CARD_DATA_DW from package AcqCard; SHALL add the FSM state typedef (IDLE, RESP) and a region enum (ST_REGION, CTRL_REGION, ERR_REGION) to that package.
REQ-029 SHALL factor address decode into one combinational sub-module acq_card_addr_decode (addr -> region, index).

Verification
REQ-030 Single read ctrl: ctrl_reg[0]=0x1234_5678, read addr 35 with rd_resp_ready=1 -> rd_resp_valid next cycle, data 0x1234_5678, err 0.
REQ-031 Coherent snapshot: st_reg[5]=0xA, read addr 0, then change st_reg[5]=0xB, read addr 5 -> data 0xA; snap_cnt=1.
REQ-032 Error decode: read addr 206 and addr 300 -> data 0, err 1 each.
REQ-033 Backpressure: rd_resp_ready=0 for 4 cycles after request -> rd_req_ready=0, response held stable, released on first ready cycle; back-to-back reads of addrs 35,36,37 with ready=1 -> three responses on consecutive cycles in order.
REQ-034 Reset mid-op: rst_n low in RESP cycle -> next cycle rd_resp_valid=0, snap_cnt=0, snapshot reads return 0 until next addr-0 read.
REQ-035 Wrap: 65536 reads of addr 0 -> snap_cnt returns to 0x0000.

Source files
------------

// File: rtl/acq_card_reg_read_resp_pkg.sv
// Shared constants and types for the acquisition-card register read path.
package AcqCard;

  localparam int ACQ_CARD_DATA_DW      = 32;
  localparam int MEM_AW                = 9;
  localparam int ST_REG_NUM            = 35;
  localparam int ACQ_CARD_REG_NUM      = 171;
  localparam int ACQ_CARD_REG_REAL_NUM = 160;

  localparam int ST_IW   = $clog2(ST_REG_NUM);
  localparam int CTRL_IW = $clog2(ACQ_CARD_REG_NUM);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } rd_state_t;

  typedef enum logic [1:0] {
    ST_REGION   = 2'd0,
    CTRL_REGION = 2'd1,
    ERR_REGION  = 2'd2
  } region_t;

endpackage

// File: rtl/acq_card_addr_decode.sv
// Host word address -> register region and index within that region.
module acq_card_addr_decode
  import AcqCard::*;
#(
  parameter int AW = MEM_AW
) (
  input  logic [AW-1:0]      addr,
  output region_t            region,
  output logic [CTRL_IW-1:0] index
);

  localparam logic [AW-1:0] ST_END = AW'(ST_REG_NUM);
  // Control slots past the implemented count decode as errors, same as addresses past the map.
  localparam logic [AW-1:0] CTRL_END = AW'(ST_REG_NUM + ACQ_CARD_REG_REAL_NUM);

  always_comb begin
    region = ERR_REGION;
    index  = '0;
    if (addr < ST_END) begin
      region = ST_REGION;
      index  = CTRL_IW'(addr);
    end else if (addr < CTRL_END) begin
      region = CTRL_REGION;
      index  = CTRL_IW'(addr - ST_END);
    end
  end

endmodule

// File: rtl/acq_card_reg_read_resp.sv
// Read-side register responder: status words (coherent via snapshot) and control words.
module acq_card_reg_read_resp
  import AcqCard::*;
#(
  parameter int DW = ACQ_CARD_DATA_DW,
  parameter int AW = MEM_AW
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rd_req_valid,
  output logic                           rd_req_ready,
  input  logic [AW-1:0]                  rd_req_addr,
  output logic                           rd_resp_valid,
  input  logic                           rd_resp_ready,
  output logic [DW-1:0]                  rd_resp_data,
  output logic                           rd_resp_err,
  input  logic [ST_REG_NUM*DW-1:0]       st_reg,
  input  logic [ACQ_CARD_REG_NUM*DW-1:0] ctrl_reg,
  output logic [15:0]                    snap_cnt,
  output logic                           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the sender
  // holds valid and payload unchanged until then, and ready never depends on anything
  // but state, reset and the downstream ready.

  rd_state_t          state;
  region_t            region;
  logic [CTRL_IW-1:0] index;
  logic               req_hs;
  logic               snap_take;
  logic [DW-1:0]      next_data;
  logic               next_err;

  logic [DW-1:0] snap   [ST_REG_NUM];
  logic [DW-1:0] st_w   [ST_REG_NUM];
  logic [DW-1:0] ctrl_w [ACQ_CARD_REG_NUM];

  for (genvar i = 0; i < ST_REG_NUM; i++) begin : g_st
    assign st_w[i] = st_reg[i*DW +: DW];
  end

  for (genvar i = 0; i < ACQ_CARD_REG_NUM; i++) begin : g_ctrl
    assign ctrl_w[i] = ctrl_reg[i*DW +: DW];
  end

  acq_card_addr_decode #(.AW(AW)) u_decode (
    .addr   (rd_req_addr),
    .region (region),
    .index  (index)
  );

  assign rd_req_ready  = rst_n & ((state == IDLE) | rd_resp_ready);
  assign req_hs        = rd_req_valid & rd_req_ready;
  assign snap_take     = req_hs && (region == ST_REGION) && (index == '0);
  assign rd_resp_valid = (state == RESP);
  assign dbg_state     = state;

  // Word 0 is served live; it is the read that freezes the rest of the status block.
  always_comb begin
    next_data = '0;
    next_err  = 1'b0;
    case (region)
      ST_REGION:   next_data = (index == '0) ? st_w[0] : snap[ST_IW'(index)];
      CTRL_REGION: next_data = ctrl_w[index];
      default:     next_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rd_resp_data <= '0;
      rd_resp_err  <= 1'b0;
      snap_cnt     <= '0;
      for (int i = 0; i < ST_REG_NUM; i++) snap[i] <= '0;
    end else begin
      if (req_hs) begin
        state        <= RESP;
        rd_resp_data <= next_data;
        rd_resp_err  <= next_err;
      end else if ((state == RESP) && rd_resp_ready) begin
        state <= IDLE;
      end
      if (snap_take) begin
        for (int i = 0; i < ST_REG_NUM; i++) snap[i] <= st_w[i];
        snap_cnt <= snap_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_acq_card_reg_read_resp.sv
// Randomized and directed checks of the register read responder against a queue-based model.
module tb_acq_card_reg_read_resp;
  import AcqCard::*;

  localparam int DW = 32;
  localparam int AW = 9;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                           rst_n;
  logic                           rd_req_valid;
  logic                           rd_req_ready;
  logic [AW-1:0]                  rd_req_addr;
  logic                           rd_resp_valid;
  logic                           rd_resp_ready;
  logic [DW-1:0]                  rd_resp_data;
  logic                           rd_resp_err;
  logic [ST_REG_NUM*DW-1:0]       st_reg;
  logic [ACQ_CARD_REG_NUM*DW-1:0] ctrl_reg;
  logic [15:0]                    snap_cnt;
  logic                           dbg_state;

  acq_card_reg_read_resp #(.DW(DW), .AW(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_req_addr   (rd_req_addr),
    .rd_resp_valid (rd_resp_valid),
    .rd_resp_ready (rd_resp_ready),
    .rd_resp_data  (rd_resp_data),
    .rd_resp_err   (rd_resp_err),
    .st_reg        (st_reg),
    .ctrl_reg      (ctrl_reg),
    .snap_cnt      (snap_cnt),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;

  logic [DW:0]   exp_q[$];            // {err, data} of responses owed to the host
  logic [DW-1:0] m_snap [ST_REG_NUM];
  logic [15:0]   m_cnt;
  bit            m_rst;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_read(input logic [AW-1:0] addr, output logic [DW:0] resp);
    int a;
    a = int'(addr);
    if (a < ST_REG_NUM) begin
      if (a == 0) begin
        for (int i = 0; i < ST_REG_NUM; i++) m_snap[i] = st_reg[i*DW +: DW];
        m_cnt++;
        resp = {1'b0, st_reg[DW-1:0]};
      end else begin
        resp = {1'b0, m_snap[a]};
      end
    end else if (a - ST_REG_NUM < ACQ_CARD_REG_REAL_NUM) begin
      resp = {1'b0, ctrl_reg[(a - ST_REG_NUM)*DW +: DW]};
    end else begin
      resp = {1'b1, {DW{1'b0}}};
    end
  endtask

  task automatic model_step();
    bit          accept;
    logic [DW:0] resp;
    if (!rst_n) begin
      exp_q.delete();
      m_cnt = '0;
      for (int i = 0; i < ST_REG_NUM; i++) m_snap[i] = '0;
      m_rst = 1'b1;
    end else begin
      m_rst  = 1'b0;
      accept = rd_req_valid && (exp_q.size() == 0 || rd_resp_ready);
      if (exp_q.size() != 0 && rd_resp_ready) void'(exp_q.pop_front());
      if (accept) begin
        model_read(rd_req_addr, resp);
        exp_q.push_back(resp);
      end
    end
  endtask

  task automatic compare();
    bit pend;
    pend = (exp_q.size() != 0);
    chk("rd_req_ready", rd_req_ready, rst_n && (!pend || rd_resp_ready));
    chk("rd_resp_valid", rd_resp_valid, pend);
    chk("dbg_state", dbg_state, pend);
    if (pend) begin
      chk("rd_resp_data", rd_resp_data, exp_q[0][DW-1:0]);
      chk("rd_resp_err", rd_resp_err, exp_q[0][DW]);
    end
    if (m_rst) begin
      chk("rst_data", rd_resp_data, 0);
      chk("rst_err", rd_resp_err, 0);
    end
    chk("snap_cnt", snap_cnt, m_cnt);
  endtask

  // One clock: model absorbs the inputs the DUT sampled, then outputs are compared.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  // ---------------- drivers ----------------
  task automatic set_st(input int i, input logic [DW-1:0] v);
    st_reg[i*DW +: DW] = v;
  endtask

  task automatic set_ctrl(input int i, input logic [DW-1:0] v);
    ctrl_reg[i*DW +: DW] = v;
  endtask

  task automatic rand_cycle();
    rst_n         = ($urandom_range(0, 299) != 0);
    rd_req_valid  = ($urandom_range(0, 3) != 0);
    rd_resp_ready = ($urandom_range(0, 2) != 0);
    case ($urandom_range(0, 5))
      0: rd_req_addr = '0;
      1: rd_req_addr = AW'($urandom_range(1, ST_REG_NUM - 1));
      2: rd_req_addr = AW'($urandom_range(ST_REG_NUM, ST_REG_NUM + ACQ_CARD_REG_REAL_NUM - 1));
      3: rd_req_addr = AW'($urandom_range(ST_REG_NUM + ACQ_CARD_REG_REAL_NUM - 2,
                                          ST_REG_NUM + ACQ_CARD_REG_NUM + 2));
      4: rd_req_addr = AW'($urandom_range(0, (1 << AW) - 1));
      default: begin
        case ($urandom_range(0, 3))
          0: rd_req_addr = AW'(ST_REG_NUM - 1);
          1: rd_req_addr = AW'(ST_REG_NUM);
          2: rd_req_addr = AW'(ST_REG_NUM + ACQ_CARD_REG_REAL_NUM - 1);
          default: rd_req_addr = AW'(ST_REG_NUM + ACQ_CARD_REG_NUM);
        endcase
      end
    endcase
    if ($urandom_range(0, 1) == 0) set_st($urandom_range(0, ST_REG_NUM - 1), $urandom());
    if ($urandom_range(0, 3) == 0) set_ctrl($urandom_range(0, ACQ_CARD_REG_NUM - 1), $urandom());
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n         = 1'b0;
    rd_req_valid  = 1'b0;
    rd_resp_ready = 1'b1;
    rd_req_addr   = '0;
    st_reg        = '0;
    ctrl_reg      = '0;
    m_cnt         = '0;
    m_rst         = 1'b1;
    for (int i = 0; i < ST_REG_NUM; i++) m_snap[i] = '0;

    // reset state
    repeat (3) tick();
    chk("reset_valid", rd_resp_valid, 0);
    chk("reset_req_ready", rd_req_ready, 0);
    chk("reset_snap_cnt", snap_cnt, 0);
    rst_n = 1'b1;
    tick();

    // single control read
    set_ctrl(0, 32'h1234_5678);
    rd_req_addr  = 9'd35;
    rd_req_valid = 1'b1;
    tick();
    rd_req_valid = 1'b0;
    chk("ctrl_valid", rd_resp_valid, 1);
    chk("ctrl_data", rd_resp_data, 32'h1234_5678);
    chk("ctrl_err", rd_resp_err, 0);
    tick();
    chk("ctrl_done", rd_resp_valid, 0);

    // coherent snapshot
    set_st(5, 32'hA);
    rd_req_addr  = 9'd0;
    rd_req_valid = 1'b1;
    tick();
    set_st(5, 32'hB);
    rd_req_addr = 9'd5;
    tick();
    rd_req_valid = 1'b0;
    chk("snap_data", rd_resp_data, 32'hA);
    chk("snap_err", rd_resp_err, 0);
    chk("snap_cnt_one", snap_cnt, 16'd1);
    tick();

    // decode errors
    rd_req_addr  = 9'd206;
    rd_req_valid = 1'b1;
    tick();
    chk("err206_data", rd_resp_data, 0);
    chk("err206_err", rd_resp_err, 1);
    rd_req_addr = 9'd300;
    tick();
    rd_req_valid = 1'b0;
    chk("err300_data", rd_resp_data, 0);
    chk("err300_err", rd_resp_err, 1);
    tick();

    // backpressure
    set_ctrl(1, 32'hCAFE_0001);
    set_ctrl(2, 32'h0000_0022);
    rd_resp_ready = 1'b0;
    rd_req_addr   = 9'd36;
    rd_req_valid  = 1'b1;
    tick();
    rd_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_req_ready", rd_req_ready, 0);
      chk("bp_valid", rd_resp_valid, 1);
      chk("bp_data", rd_resp_data, 32'hCAFE_0001);
      tick();
    end
    rd_resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", rd_req_ready, 1);
    tick();
    chk("bp_released", rd_resp_valid, 0);

    // back-to-back
    rd_req_valid = 1'b1;
    rd_req_addr  = 9'd35;
    tick();
    chk("b2b_0", rd_resp_data, 32'h1234_5678);
    rd_req_addr = 9'd36;
    tick();
    chk("b2b_1", rd_resp_data, 32'hCAFE_0001);
    rd_req_addr = 9'd37;
    tick();
    rd_req_valid = 1'b0;
    chk("b2b_2", rd_resp_data, 32'h0000_0022);
    chk("b2b_2_valid", rd_resp_valid, 1);
    tick();
    chk("b2b_idle", rd_resp_valid, 0);

    // reset mid-transaction
    set_st(3, 32'h33);
    rd_req_addr  = 9'd0;
    rd_req_valid = 1'b1;
    tick();
    rd_req_valid = 1'b0;
    tick();
    rd_resp_ready = 1'b0;
    rd_req_addr   = 9'd3;
    rd_req_valid  = 1'b1;
    tick();
    rd_req_valid = 1'b0;
    chk("mid_pending_data", rd_resp_data, 32'h33);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", rd_resp_valid, 0);
    chk("mid_rst_cnt", snap_cnt, 0);
    rst_n         = 1'b1;
    rd_resp_ready = 1'b1;
    tick();
    chk("mid_no_resp", rd_resp_valid, 0);
    rd_req_addr  = 9'd5;
    rd_req_valid = 1'b1;
    tick();
    rd_req_valid = 1'b0;
    chk("mid_snap_cleared", rd_resp_data, 0);
    tick();

    // randomized traffic
    repeat (3000) rand_cycle();

    // snapshot counter wrap
    rst_n         = 1'b0;
    rd_req_valid  = 1'b0;
    rd_resp_ready = 1'b1;
    tick();
    rst_n        = 1'b1;
    rd_req_addr  = 9'd0;
    rd_req_valid = 1'b1;
    repeat (65535) tick();
    chk("wrap_ffff", snap_cnt, 16'hFFFF);
    tick();
    chk("wrap_zero", snap_cnt, 16'h0000);
    rd_req_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
